// File: rtl/mc_core_ctrl_if.sv
// Memory-side handshake of the multicycle sequencer: request/ready plus the
// address-select and store strobes that travel with a request, and read data.
// Ports: mem_req, adr_src, mem_write (controller -> memory); mem_ready, mem_rdata (memory -> controller).
interface mc_core_ctrl_if;
    logic        mem_req;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        adr_src;
    logic        mem_write;

    modport master (
        output mem_req,
        output adr_src,
        output mem_write,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  adr_src,
        input  mem_write,
        output mem_ready,
        output mem_rdata
    );
endinterface

// File: rtl/mc_core_ctrl.sv
// Multicycle RV32I sequencer: owns PC, OldPC, IR and the control FSM, driving datapath selects/strobes.
// Latency (no memory wait): branch 3, R/I/LUI/AUIPC/JAL/JALR/store 4, load 5 cycles; +1 per mem_ready wait.
// Backpressure: mem_req held until mem_ready; FSM stalls in FETCH/MEMREAD/MEMWRITE meanwhile.
// Ports: clk, reset (sync, active-high); bus (memory handshake, master); i_result, i_zero/i_sign/i_carry/i_overflow;
//        o_pc, o_old_pc, o_instr, o_ir_write/o_pc_write/o_reg_write, o_result_src, o_alu_src_a/b,
//        o_alu_control, o_imm_src, o_state_dbg; o_illegal_instr only when MC_CTRL_ILLEGAL_TRAP_EN is defined.
// Build option MC_CTRL_ILLEGAL_TRAP_EN: illegal instructions park the FSM in TRAP until reset
// (otherwise they retire as a NOP straight back to FETCH).
module mc_core_ctrl #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = 'h1000
) (
    input  logic                clk,
    input  logic                reset,
    mc_core_ctrl_if.master      bus,
    input  logic [XLEN-1:0]     i_result,
    input  logic                i_zero,
    input  logic                i_sign,
    input  logic                i_carry,
    input  logic                i_overflow,
    output logic [XLEN-1:0]     o_pc,
    output logic [XLEN-1:0]     o_old_pc,
    output logic [31:0]         o_instr,
    output logic                o_ir_write,
    output logic                o_pc_write,
    output logic                o_reg_write,
    output logic [1:0]          o_result_src,
    output logic [1:0]          o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [3:0]          o_alu_control,
    output logic [2:0]          o_imm_src,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    output logic                o_illegal_instr,
`endif
    output logic [3:0]          o_state_dbg
);
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR, S_EXECI,
        S_ALUWB, S_JAL, S_JALR, S_BRANCH, S_LUI, S_AUIPC, S_TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD = 7'b0000011, OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011,
                           OP_OP   = 7'b0110011, OP_OPIMM = 7'b0010011, OP_JAL    = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_LUI   = 7'b0110111, OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD = 4'h0, ALU_SUB = 4'h1, ALU_AND = 4'h2, ALU_OR  = 4'h3,
                           ALU_XOR = 4'h4, ALU_SLT = 4'h5, ALU_SLTU = 4'h6, ALU_SLL = 4'h7,
                           ALU_SRL = 4'h8, ALU_SRA = 4'h9, ALU_PASSB = 4'hA;

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_pc, r_old_pc;
    logic [31:0]     r_instr;

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_funct7b5;
    logic            w_legal;
    logic            w_taken;
    logic [3:0]      w_alu_op;
    logic [XLEN-1:0] w_pc_next;

    assign w_opcode   = r_instr[6:0];
    assign w_funct3   = r_instr[14:12];
    assign w_funct7b5 = r_instr[30];

    // Opcode legality, including the funct3 holes in LOAD/STORE/BRANCH.
    always_comb begin
        w_legal = 1'b0;
        case (w_opcode)
            OP_LOAD:   w_legal = (w_funct3 != 3'b011) && (w_funct3 != 3'b110) && (w_funct3 != 3'b111);
            OP_STORE:  w_legal = (w_funct3 < 3'b011);
            OP_BRANCH: w_legal = (w_funct3 != 3'b010) && (w_funct3 != 3'b011);
            OP_OP, OP_OPIMM, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            default:   w_legal = 1'b0;
        endcase
    end

    // Branch condition from flags of rs1 - rs2; carry=1 means no borrow.
    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = i_zero;
            3'b001:  w_taken = !i_zero;
            3'b100:  w_taken = i_sign ^ i_overflow;
            3'b101:  w_taken = !(i_sign ^ i_overflow);
            3'b110:  w_taken = !i_carry;
            3'b111:  w_taken = i_carry;
            default: w_taken = 1'b0;
        endcase
    end

    // funct7[5] selects SUB only for register ops; it selects SRA for both SRL/SRLI forms.
    always_comb begin
        w_alu_op = ALU_ADD;
        case (w_funct3)
            3'b000:  w_alu_op = (w_opcode == OP_OP && w_funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  w_alu_op = ALU_SLL;
            3'b010:  w_alu_op = ALU_SLT;
            3'b011:  w_alu_op = ALU_SLTU;
            3'b100:  w_alu_op = ALU_XOR;
            3'b101:  w_alu_op = w_funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  w_alu_op = ALU_OR;
            default: w_alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        w_state_next  = r_state;
        bus.mem_req   = 1'b0;
        bus.adr_src   = 1'b0;
        bus.mem_write = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_reg_write   = 1'b0;
        o_result_src  = 2'b00;
        o_alu_src_a   = 2'b00;
        o_alu_src_b   = 2'b00;
        o_alu_control = ALU_ADD;
        o_imm_src     = 3'b000;
        case (r_state)
            S_FETCH: begin
                bus.mem_req  = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                if (bus.mem_ready) begin
                    o_ir_write   = 1'b1;
                    o_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // alu_reg is primed with the jump target so JAL/JALR can
                // spend their own cycle computing the link value old_pc+4.
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
                o_imm_src   = 3'b010;
                if (w_opcode == OP_JAL) begin
                    o_imm_src = 3'b011;
                end else if (w_opcode == OP_JALR) begin
                    o_alu_src_a = 2'b10;
                    o_imm_src   = 3'b000;
                end
                if (!w_legal) begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                    w_state_next = S_TRAP;
`else
                    w_state_next = S_FETCH;
`endif
                end else begin
                    case (w_opcode)
                        OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                        OP_OP:             w_state_next = S_EXECR;
                        OP_OPIMM:          w_state_next = S_EXECI;
                        OP_JAL:            w_state_next = S_JAL;
                        OP_JALR:           w_state_next = S_JALR;
                        OP_BRANCH:         w_state_next = S_BRANCH;
                        OP_LUI:            w_state_next = S_LUI;
                        default:           w_state_next = S_AUIPC;
                    endcase
                end
            end
            S_MEMADR: begin
                o_alu_src_a  = 2'b10;
                o_alu_src_b  = 2'b01;
                o_imm_src    = (w_opcode == OP_STORE) ? 3'b001 : 3'b000;
                w_state_next = (w_opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.mem_req = 1'b1;
                bus.adr_src = 1'b1;
                if (bus.mem_ready) w_state_next = S_MEMWB;
            end
            S_MEMWB: begin
                o_result_src = 2'b01;
                o_reg_write  = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_write = 1'b1;
                bus.adr_src   = 1'b1;
                if (bus.mem_ready) w_state_next = S_FETCH;
            end
            S_EXECR: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = w_alu_op;
                w_state_next  = S_ALUWB;
            end
            S_EXECI: begin
                o_alu_src_a   = 2'b10;
                o_alu_src_b   = 2'b01;
                o_alu_control = w_alu_op;
                w_state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                o_reg_write  = 1'b1;
                w_state_next = S_FETCH;
            end
            S_JAL, S_JALR: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b10;
                o_pc_write   = 1'b1;
                w_state_next = S_ALUWB;
            end
            S_BRANCH: begin
                o_alu_src_a   = 2'b10;
                o_alu_control = ALU_SUB;
                o_imm_src     = 3'b010;
                o_pc_write    = w_taken;
                w_state_next  = S_FETCH;
            end
            S_LUI: begin
                o_alu_src_b   = 2'b01;
                o_imm_src     = 3'b100;
                o_alu_control = ALU_PASSB;
                w_state_next  = S_ALUWB;
            end
            S_AUIPC: begin
                o_alu_src_a  = 2'b01;
                o_alu_src_b  = 2'b01;
                o_imm_src    = 3'b100;
                w_state_next = S_ALUWB;
            end
            S_TRAP: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
                w_state_next = S_TRAP;
`else
                w_state_next = S_FETCH;
`endif
            end
            default: w_state_next = S_FETCH;
        endcase
        // Nothing leaves the block while reset is held, so an aborted access
        // never commits a write.
        if (reset) begin
            bus.mem_req   = 1'b0;
            bus.mem_write = 1'b0;
            o_ir_write    = 1'b0;
            o_pc_write    = 1'b0;
            o_reg_write   = 1'b0;
        end
    end

    // JALR target has bit 0 cleared; all other PC updates take the result mux as-is.
    assign w_pc_next = (r_state == S_JALR) ? {i_result[XLEN-1:1], 1'b0} : i_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_FETCH;
            r_pc     <= RESET_VECTOR;
            r_old_pc <= '0;
            r_instr  <= 32'h0000_0013;
        end else begin
            r_state <= w_state_next;
            if (o_ir_write) begin
                r_instr  <= bus.mem_rdata;
                r_old_pc <= r_pc;
            end
            if (o_pc_write) r_pc <= w_pc_next;
        end
    end

    assign o_pc        = r_pc;
    assign o_old_pc    = r_old_pc;
    assign o_instr     = r_instr;
    assign o_state_dbg = r_state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    assign o_illegal_instr = (r_state == S_TRAP);
`endif
endmodule
